// File: rtl/serial_r.sv
// 8N1 UART receiver: double-flop synchronizes RDX, detects the start bit,
// samples each data/stop bit at mid-period and strobes the received byte.
module serial_r #(
  parameter int CLKS_PER_BIT = 5201,
  parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       RDX,
  output logic [7:0] dataout,
  output logic       complete,
  output logic       ferr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);

  state_t      state;
  state_t      state_d;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        rx_meta;
  logic        rx_s;
  logic        bit_end;
  logic        half_pt;

  // NOTE: both synchronizer flops reset to the idle (high) line level so that
  // leaving reset never looks like a falling start edge.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RDX;
      rx_s    <= rx_meta;
    end
  end

  assign bit_end = (cnt == LAST_CNT);
  assign half_pt = (cnt == HALF_CNT);

  // State register.
  always_ff @(posedge m_clock) begin
    if (p_reset) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state;
    case (state)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (half_pt) state_d = rx_s ? IDLE : DATA;
      DATA:    if (bit_end && (idx == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = rx_s ? IDLE : WAITHI;
      WAITHI:  if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, shift register and registered strobes.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      cnt      <= 16'd0;
      idx      <= 3'd0;
      shift    <= 8'h00;
      dataout  <= 8'h00;
      complete <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block
      // sees the pre-edge value regardless of statement order.
      complete <= 1'b0;
      ferr     <= 1'b0;
      case (state)
        START: begin
          if (half_pt) begin
            cnt <= 16'd0;
            idx <= 3'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift[idx] <= rx_s;
            cnt        <= 16'd0;
            if (idx != 3'd7) idx <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= 16'd0;
            // A low stop bit discards the byte; dataout keeps the last good one.
            if (rx_s) begin
              dataout  <= shift;
              complete <= 1'b1;
            end else begin
              ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt <= 16'd0;
          idx <= 3'd0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_r.sv
// Self-checking bench for serial_r: table-driven frames, hand-written corner
// sequences, randomized frames against a byte-queue model, and a latency run.
module tb_serial_r;

  localparam int CPB  = 16;
  localparam int HB   = 7;
  localparam int DCPB = 5201;
  localparam int DHB  = 2600;
  localparam int LAT  = 2 + 1 + DHB + 9 * DCPB;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       RDX;
  logic       d_rdx;
  logic [7:0] dataout;
  logic [7:0] d_dataout;
  logic       complete, ferr, busy;
  logic       d_complete, d_ferr, d_busy;

  int checks = 0;
  int errors = 0;
  int complete_cnt = 0;
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  int wide_cnt = 0;
  logic prev_complete = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] rx_q[$];

  always #5 m_clock = ~m_clock;

  serial_r #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .RDX      (RDX),
    .dataout  (dataout),
    .complete (complete),
    .ferr     (ferr),
    .busy     (busy)
  );

  serial_r dut_def (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .RDX      (d_rdx),
    .dataout  (d_dataout),
    .complete (d_complete),
    .ferr     (d_ferr),
    .busy     (d_busy)
  );

  // Strobe monitor: records received bytes and pulse-shape violations.
  always @(negedge m_clock) begin
    if (complete === 1'b1) begin
      complete_cnt++;
      rx_q.push_back(dataout);
    end
    if (ferr === 1'b1) ferr_cnt++;
    if (complete === 1'b1 && ferr === 1'b1) overlap_cnt++;
    if ((complete === 1'b1 && prev_complete) || (ferr === 1'b1 && prev_ferr)) wide_cnt++;
    prev_complete = (complete === 1'b1);
    prev_ferr     = (ferr === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge m_clock);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d);
    RDX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RDX = d[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low);
    send_head(d);
    if (stop_low > 0) begin
      RDX = 1'b0;
      tick(stop_low);
    end
    RDX = 1'b1;
    tick(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         exp_c;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, f0, exp_f, lat;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic [7:0] lat_byte;
    bit bad;

    vecs[0] = '{8'hA5, 0, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 0, 1, 0, 8'hFF};
    vecs[3] = '{8'h55, 40, 0, 1, 8'hFF};
    vecs[4] = '{8'h12, 0, 1, 0, 8'h12};

    p_reset = 1'b1;
    RDX     = 1'b1;
    d_rdx   = 1'b1;
    tick(3);
    p_reset = 1'b0;
    check("reset_dataout", dataout, 8'h00);
    check("reset_complete", complete, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    check("reset_busy", busy, 1'b0);
    tick(5);

    // Table-driven frames; consecutive entries are sent with no idle gap.
    for (int v = 0; v < 5; v++) begin
      c0 = complete_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop_low);
      check($sformatf("vec%0d_complete", v), complete_cnt - c0, vecs[v].exp_c);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_f);
      check($sformatf("vec%0d_dataout", v), dataout, vecs[v].exp_d);
      check($sformatf("vec%0d_busy", v), busy, 1'b0);
    end

    // Short low glitch must be rejected at the half-bit re-check.
    c0 = complete_cnt;
    f0 = ferr_cnt;
    RDX = 1'b0;
    tick(4);
    check("glitch_busy_high", busy, 1'b1);
    RDX = 1'b1;
    tick(20);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_complete", complete_cnt - c0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, 0);
    check("after_glitch_dataout", dataout, 8'h3C);
    check("after_glitch_complete", complete_cnt - c0, 1);

    // Held-low stop bit: ferr once, busy until the line returns high.
    c0 = complete_cnt;
    f0 = ferr_cnt;
    send_head(8'h55);
    RDX = 1'b0;
    tick(30);
    check("waithi_busy", busy, 1'b1);
    check("waithi_ferr", ferr_cnt - f0, 1);
    check("waithi_dataout", dataout, 8'h3C);
    tick(10);
    RDX = 1'b1;
    tick(CPB);
    check("waithi_release_busy", busy, 1'b0);
    send_frame(8'h12, 0);
    check("after_ferr_dataout", dataout, 8'h12);
    check("after_ferr_complete", complete_cnt - c0, 1);
    check("after_ferr_ferr", ferr_cnt - f0, 1);

    // Reset during data bit 4 of 8'hC3.
    c0 = complete_cnt;
    f0 = ferr_cnt;
    d = 8'hC3;
    RDX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      RDX = d[i];
      tick(CPB);
    end
    RDX = d[4];
    tick(8);
    p_reset = 1'b1;
    tick(1);
    p_reset = 1'b0;
    RDX = 1'b1;
    check("midreset_dataout", dataout, 8'h00);
    check("midreset_complete", complete, 1'b0);
    check("midreset_ferr", ferr, 1'b0);
    check("midreset_busy", busy, 1'b0);
    tick(40);
    check("midreset_no_strobe", complete_cnt - c0, 0);
    check("midreset_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h81, 0);
    check("after_reset_dataout", dataout, 8'h81);
    check("after_reset_complete", complete_cnt - c0, 1);

    // Randomized frames: every good frame yields its byte, every bad stop one ferr.
    rx_q.delete();
    f0 = ferr_cnt;
    exp_f = 0;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      if (bad) exp_f++;
      else     exp_q.push_back(d);
      send_frame(d, bad ? 20 : 0);
      tick($urandom_range(0, 12));
    end
    tick(30);
    check("rand_count", rx_q.size(), exp_q.size());
    check("rand_ferr", ferr_cnt - f0, exp_f);
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check($sformatf("rand_byte%0d", k), rx_q[k], exp_q[k]);

    check("no_overlap", overlap_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    // Default-parameter latency from the start-bit falling edge.
    lat = -1;
    lat_byte = 8'h5A;
    fork
      begin
        d_rdx = 1'b0;
        tick(DCPB);
        for (int i = 0; i < 8; i++) begin
          d_rdx = lat_byte[i];
          tick(DCPB);
        end
        d_rdx = 1'b1;
        tick(DCPB);
      end
      begin
        for (int n = 1; n <= LAT + 200; n++) begin
          @(posedge m_clock);
          @(negedge m_clock);
          if (d_complete === 1'b1) begin
            lat = n;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < LAT - 2 || lat > LAT + 2) begin
      errors++;
      $display("FAIL default_latency actual=%0d required=%0d+-2", lat, LAT);
    end
    check("default_dataout", d_dataout, 8'h5A);
    check("default_busy", d_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_r.md
Name: serial_r

Overview:
- 8N1 UART receiver. Counterpart of the team's serial transmitter: same line format, bit period and clock/reset naming.
- Oversamples the asynchronous RDX line with m_clock, detects the start bit, and samples each bit at mid-period.
- Presents the received byte with a one-cycle complete strobe.
- Flags framing errors on a bad stop bit. Sits between the board RX pin and the byte-consuming logic.

Parameters:
- CLKS_PER_BIT, 5201, m_clock cycles per UART bit. Bit counter runs 0..CLKS_PER_BIT-1.
- HALF_BIT, (CLKS_PER_BIT-1)/2 = 2600, counter value at which the start bit is re-checked.

Ports:
- m_clock  input  1  system clock; all logic on its rising edge
- p_reset  input  1  synchronous, active-high reset
- RDX  input  1  serial line, idle high, asynchronous to m_clock
- dataout  output  8  last correctly received byte, LSB = first data bit
- complete  output  1  one-cycle pulse: dataout updated this cycle
- ferr  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (m_clock). Reset p_reset is synchronous and active-high, sampled only on the m_clock rising edge.
- Reset values: state=IDLE, cnt=0, idx=0, shift=0, dataout=8'h00, complete=0, ferr=0, busy=0. Both synchronizer flops reset to 1.
- Synchronizer: RDX passes through 2 flops to give rx_s. All decisions use rx_s only; rx_s lags RDX by 2 cycles.
- cnt: 16-bit. idx: 3-bit.
- State IDLE:
  - cnt=0.
  - rx_s==0 -> START, cnt=0.
- State START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT: if rx_s==0 -> DATA, cnt=0, idx=0. If rx_s==1 -> IDLE (glitch reject, no strobe).
- State DATA:
  - cnt increments.
  - At cnt==CLKS_PER_BIT-1: shift[idx]<=rx_s, cnt=0.
  - If idx==7 -> STOP, otherwise idx<=idx+1.
  - Sample points therefore fall at mid-bit.
- State STOP:
  - cnt increments.
  - At cnt==CLKS_PER_BIT-1 with rx_s==1: dataout<=shift, complete=1 for that single cycle, -> IDLE. Returning at mid-stop-bit allows back-to-back frames.
  - At cnt==CLKS_PER_BIT-1 with rx_s==0: ferr=1 for one cycle, dataout unchanged, -> WAITHI.
- State WAITHI: stay until rx_s==1, then -> IDLE. This covers break conditions and prevents a false start on a line held low.
- complete and ferr are registered and never high together. Each is high for exactly one cycle per frame.
- busy=1 in START, DATA, STOP and WAITHI.
- dataout holds its value until the next good frame.
- Latency: complete rises CLKS_PER_BIT-1+1 cycles after the mid-stop-bit sample point counter start. Measured from the RDX falling edge of the start bit, this is 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT cycles, ±1.
- Reset mid-frame: p_reset high in any state returns to IDLE next edge. Partial byte is discarded, no strobe. If RDX is low when reset releases, a new START is entered, as for any low line.
- Counter width: 16 bits suffices for CLKS_PER_BIT ≤ 65535. The comparison is equality only, with no wrap in normal operation.

Test Plan (bench sets CLKS_PER_BIT=16, HALF_BIT=7 unless noted):
- Byte 8'hA5 sent 8N1 on RDX after reset:
  - complete pulses once, 1 cycle wide; dataout=8'hA5; ferr stays 0; busy returns to 0.
- Two back-to-back frames 8'h00 then 8'hFF, no idle gap (stop bit length exactly 16 cycles):
  - two complete pulses; dataout=8'h00, then 8'hFF.
- RDX low for 4 cycles then high (glitch):
  - START aborts at cnt==7; no complete/ferr; busy drops; next valid frame 8'h3C received correctly.
- Frame 8'h55 with stop bit driven 0 for 40 cycles, then high:
  - ferr pulses once; dataout keeps the previous value; busy stays 1 until rx_s returns high; following frame 8'h12 gives complete with dataout=8'h12.
- p_reset asserted for 1 cycle during data bit 4 of frame 8'hC3:
  - next cycle all outputs are at reset values; no complete for the aborted frame; subsequent frame 8'h81 received correctly.
- Default parameter (5201), frame 8'h5A:
  - complete asserts within ±2 cycles of 2+1+2600+9*5201 after the start falling edge; dataout=8'h5A.
